// File: rtl/float_to_int_pkg.sv
// Single-precision float constants and classification shared by the float pipeline stages.
package float_to_int_pkg;

    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;
    localparam int MANT_W  = 23;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;

    localparam logic [7:0] EXP_BIAS    = 8'(BIAS);
    localparam logic [7:0] EXP_SAT     = 8'(BIAS + 31);
    localparam logic [7:0] EXP_NOSHIFT = 8'(BIAS + MANT_W);
    localparam logic [7:0] EXP_SPECIAL = 8'(EXP_MAX);

    typedef enum logic [2:0] {
        CLS_NORMAL = 3'd0,
        CLS_SMALL  = 3'd1,
        CLS_BIG    = 3'd2,
        CLS_INF    = 3'd3,
        CLS_NAN    = 3'd4
    } fp_class_t;

    // SMALL folds zero, denormals and |x|<1; BIG is anything at or beyond 2^31.
    function automatic fp_class_t classify(input logic [7:0] exp, input logic [MANT_W-1:0] frac);
        fp_class_t cls;
        if (exp == EXP_SPECIAL) begin
            cls = (frac != {MANT_W{1'b0}}) ? CLS_NAN : CLS_INF;
        end else if (exp < EXP_BIAS) begin
            cls = CLS_SMALL;
        end else if (exp >= EXP_SAT) begin
            cls = CLS_BIG;
        end else begin
            cls = CLS_NORMAL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/float_to_int_if.sv
// Float-in / integer-out stream bundle with valid/ready on both sides.
interface float_to_int_if;

    logic [31:0] in_a;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_z;
    logic        out_valid;
    logic        out_ready;
    logic        out_invalid;
    logic        out_overflow;
    logic        out_inexact;

    modport slave (
        input  in_a, in_valid, out_ready,
        output in_ready, out_z, out_valid, out_invalid, out_overflow, out_inexact
    );

    modport master (
        output in_a, in_valid, out_ready,
        input  in_ready, out_z, out_valid, out_invalid, out_overflow, out_inexact
    );

endinterface

// File: rtl/float_to_int_pipe_stage_ctl.sv
// Valid bit and load/advance control for one elastic pipeline register stage.
module float_to_int_pipe_stage_ctl (
    input  logic clk,
    input  logic rst_n,
    input  logic up_valid,
    input  logic dn_load,
    output logic load,
    output logic take,
    output logic valid
);

    logic valid_r;

    // A stage can load when it is empty or its content leaves this cycle.
    always_comb begin
        load = !valid_r || dn_load;
        take = load && up_valid;
    end

    // Stage occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
        end else if (load) begin
            valid_r <= up_valid;
        end
    end

    assign valid = valid_r;

endmodule

// File: rtl/float_to_int.sv
// Three-stage float32 to int32 converter: truncates toward zero, saturates and flags exceptions.
module float_to_int
    import float_to_int_pkg::*;
#(
    parameter logic [31:0] NAN_RESULT = 32'h8000_0000,
    parameter bit          FLAG_EN    = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    float_to_int_if.slave  bus
);

    logic s1_load_s, s1_take_s, s1_valid_s;
    logic s2_load_s, s2_take_s, s2_valid_s;
    logic s3_load_s, s3_take_s, s3_valid_s;

    float_to_int_pipe_stage_ctl u_s1_ctl (
        .clk(clk), .rst_n(rst_n), .up_valid(bus.in_valid), .dn_load(s2_load_s),
        .load(s1_load_s), .take(s1_take_s), .valid(s1_valid_s)
    );
    float_to_int_pipe_stage_ctl u_s2_ctl (
        .clk(clk), .rst_n(rst_n), .up_valid(s1_valid_s), .dn_load(s3_load_s),
        .load(s2_load_s), .take(s2_take_s), .valid(s2_valid_s)
    );
    float_to_int_pipe_stage_ctl u_s3_ctl (
        .clk(clk), .rst_n(rst_n), .up_valid(s2_valid_s), .dn_load(bus.out_ready),
        .load(s3_load_s), .take(s3_take_s), .valid(s3_valid_s)
    );

    assign bus.in_ready  = s1_load_s;
    assign bus.out_valid = s3_valid_s;

    // ---------------- S1: unpack and classify ----------------
    logic                in_sign_s;
    logic [7:0]          in_exp_s;
    logic [MANT_W-1:0]   in_frac_s;
    fp_class_t           in_cls_s;
    logic                in_nz_s;
    logic                in_min_s;

    logic                s1_sign_r;
    logic [7:0]          s1_exp_r;
    logic [MANT_W:0]     s1_mant_r;
    fp_class_t           s1_cls_r;
    logic                s1_nz_r;
    logic                s1_min_r;

    // Field split; in_min_s marks exactly -2^31, the one BIG value that fits.
    always_comb begin
        in_sign_s = bus.in_a[31];
        in_exp_s  = bus.in_a[30:MANT_W];
        in_frac_s = bus.in_a[MANT_W-1:0];
        in_cls_s  = classify(in_exp_s, in_frac_s);
        in_nz_s   = (in_exp_s != 8'd0) || (in_frac_s != {MANT_W{1'b0}});
        in_min_s  = in_sign_s && (in_exp_s == EXP_SAT) && (in_frac_s == {MANT_W{1'b0}});
    end

    // S1 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sign_r <= 1'b0;
            s1_exp_r  <= 8'd0;
            s1_mant_r <= {(MANT_W+1){1'b0}};
            s1_cls_r  <= CLS_NORMAL;
            s1_nz_r   <= 1'b0;
            s1_min_r  <= 1'b0;
        end else if (s1_take_s) begin
            s1_sign_r <= in_sign_s;
            s1_exp_r  <= in_exp_s;
            s1_mant_r <= {(in_exp_s != 8'd0), in_frac_s};
            s1_cls_r  <= in_cls_s;
            s1_nz_r   <= in_nz_s;
            s1_min_r  <= in_min_s;
        end
    end

    // ---------------- S2: align mantissa to integer ----------------
    logic [31:0] m_ext_s;
    logic [7:0]  shl_s;
    logic [7:0]  shr_s;
    logic [31:0] mag_s;
    logic        lost_s;
    logic        s2_inexact_s;

    logic        s2_sign_r;
    fp_class_t   s2_cls_r;
    logic [31:0] s2_mag_r;
    logic        s2_inexact_r;
    logic        s2_min_r;

    // Shift the 24-bit significand so bit 0 has weight 1; bits dropped on the right are the inexact fraction.
    always_comb begin
        m_ext_s = {{(31-MANT_W){1'b0}}, s1_mant_r};
        shl_s   = s1_exp_r - EXP_NOSHIFT;
        shr_s   = EXP_NOSHIFT - s1_exp_r;
        if (s1_exp_r >= EXP_NOSHIFT) begin
            mag_s  = m_ext_s << shl_s;
            lost_s = 1'b0;
        end else begin
            mag_s  = m_ext_s >> shr_s;
            lost_s = |(m_ext_s & ((32'd1 << shr_s) - 32'd1));
        end
        case (s1_cls_r)
            CLS_NORMAL: s2_inexact_s = lost_s;
            CLS_SMALL:  s2_inexact_s = s1_nz_r;
            default:    s2_inexact_s = 1'b0;
        endcase
    end

    // S2 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sign_r    <= 1'b0;
            s2_cls_r     <= CLS_NORMAL;
            s2_mag_r     <= 32'd0;
            s2_inexact_r <= 1'b0;
            s2_min_r     <= 1'b0;
        end else if (s2_take_s) begin
            s2_sign_r    <= s1_sign_r;
            s2_cls_r     <= s1_cls_r;
            s2_mag_r     <= mag_s;
            s2_inexact_r <= s2_inexact_s;
            s2_min_r     <= s1_min_r;
        end
    end

    // ---------------- S3: sign, saturate, flag ----------------
    logic [31:0] z_s;
    logic        inv_s;
    logic        ovf_s;
    logic        inx_s;

    logic [31:0] out_z_r;
    logic        out_invalid_r;
    logic        out_overflow_r;
    logic        out_inexact_r;

    // Final result per class; at most one flag is raised for any input.
    always_comb begin
        z_s   = 32'd0;
        inv_s = 1'b0;
        ovf_s = 1'b0;
        inx_s = 1'b0;
        case (s2_cls_r)
            CLS_NORMAL: begin
                z_s   = s2_sign_r ? (32'd0 - s2_mag_r) : s2_mag_r;
                inx_s = s2_inexact_r;
            end
            CLS_SMALL: begin
                z_s   = 32'd0;
                inx_s = s2_inexact_r;
            end
            CLS_BIG: begin
                if (s2_min_r) begin
                    z_s = INT_MIN;
                end else begin
                    z_s   = s2_sign_r ? INT_MIN : INT_MAX;
                    ovf_s = 1'b1;
                end
            end
            CLS_INF: begin
                z_s   = s2_sign_r ? INT_MIN : INT_MAX;
                inv_s = 1'b1;
            end
            CLS_NAN: begin
                z_s   = NAN_RESULT;
                inv_s = 1'b1;
            end
            default: begin
                z_s = 32'd0;
            end
        endcase
    end

    // S3 register; it only reloads when empty or drained, which keeps a stalled output stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_z_r        <= 32'd0;
            out_invalid_r  <= 1'b0;
            out_overflow_r <= 1'b0;
            out_inexact_r  <= 1'b0;
        end else if (s3_take_s) begin
            out_z_r        <= z_s;
            out_invalid_r  <= inv_s && FLAG_EN;
            out_overflow_r <= ovf_s && FLAG_EN;
            out_inexact_r  <= inx_s && FLAG_EN;
        end
    end

    assign bus.out_z        = out_z_r;
    assign bus.out_invalid  = out_invalid_r;
    assign bus.out_overflow = out_overflow_r;
    assign bus.out_inexact  = out_inexact_r;

endmodule

// File: tb/tb_float_to_int.sv
// Directed bench for float_to_int: value table, backpressure ordering and mid-stream reset.
module tb_float_to_int;

    logic clk;
    logic rst_n;

    float_to_int_if bus ();

    float_to_int dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] flags_w;
    assign flags_w = {29'd0, bus.out_invalid, bus.out_overflow, bus.out_inexact};

    logic [31:0] bp_in [0:4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Send one float with out_ready high; expect the result in the third cycle after acceptance.
    task automatic run_vec(input string tag, input logic [31:0] a,
                           input logic [31:0] exp_z, input logic [31:0] exp_flags);
        int lat;
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_a      = a;
        bus.in_valid  = 1'b1;
        #1;
        check_eq({tag, "_rdy"}, {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_a     = 32'd0;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) break;
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'd3);
        check_eq({tag, "_z"}, bus.out_z, exp_z);
        check_eq({tag, "_flg"}, flags_w, exp_flags);
    endtask

    initial begin
        int acc;
        int got;
        int first_c;
        int last_c;
        int seen;
        logic ok;

        bp_in[0] = 32'h3F80_0000;
        bp_in[1] = 32'h4000_0000;
        bp_in[2] = 32'h4040_0000;
        bp_in[3] = 32'h4080_0000;
        bp_in[4] = 32'h40A0_0000;

        rst_n        = 1'b0;
        bus.in_a     = 32'd0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;

        #12;
        check_eq("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("rst_z", bus.out_z, 32'd0);
        check_eq("rst_flg", flags_w, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // flags are {invalid, overflow, inexact}
        run_vec("p3",     32'h4040_0000, 32'h0000_0003, 32'd0);
        run_vec("m2",     32'hC000_0000, 32'hFFFF_FFFE, 32'd0);
        run_vec("p1_5",   32'h3FC0_0000, 32'h0000_0001, 32'd1);
        run_vec("m0_5",   32'hBF00_0000, 32'h0000_0000, 32'd1);
        run_vec("mzero",  32'h8000_0000, 32'h0000_0000, 32'd0);
        run_vec("maxfit", 32'h4EFF_FFFF, 32'h7FFF_FF80, 32'd0);
        run_vec("p2p31",  32'h4F00_0000, 32'h7FFF_FFFF, 32'd2);
        run_vec("m2p31",  32'hCF00_0000, 32'h8000_0000, 32'd0);
        run_vec("mbig",   32'hCF00_0001, 32'h8000_0000, 32'd2);
        run_vec("nan",    32'h7FC0_0000, 32'h8000_0000, 32'd4);
        run_vec("pinf",   32'h7F80_0000, 32'h7FFF_FFFF, 32'd4);
        run_vec("minf",   32'hFF80_0000, 32'h8000_0000, 32'd4);

        // Backpressure: stall the output for 6 cycles while streaming 1..5.
        @(negedge clk);
        bus.out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            bus.in_valid = (acc < 5);
            bus.in_a     = bp_in[(acc < 5) ? acc : 0];
            #1;
            ok = bus.in_valid && bus.in_ready;
            @(posedge clk);
            if (ok) acc++;
            @(negedge clk);
        end
        bus.in_valid = (acc < 5);
        bus.in_a     = bp_in[(acc < 5) ? acc : 0];
        #1;
        check_eq("bp_accepted", 32'(acc), 32'd3);
        check_eq("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check_eq("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
        check_eq("bp_hold_z", bus.out_z, 32'd1);

        bus.out_ready = 1'b1;
        got     = 0;
        first_c = -1;
        last_c  = -1;
        for (int c = 0; c < 20; c++) begin
            bus.in_valid = (acc < 5);
            bus.in_a     = bp_in[(acc < 5) ? acc : 0];
            #1;
            if (bus.out_valid) begin
                check_eq("bp_order", bus.out_z, 32'(got + 1));
                if (first_c < 0) first_c = c;
                last_c = c;
                got++;
            end
            ok = bus.in_valid && bus.in_ready;
            @(posedge clk);
            if (ok) acc++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check_eq("bp_count", 32'(got), 32'd5);
        check_eq("bp_span", 32'(last_c - first_c), 32'd4);

        // Reset with one item at the output and one in S2.
        bus.out_ready = 1'b1;
        bus.in_a      = 32'h40E0_0000;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_a      = 32'h4100_0000;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_a      = 32'd0;
        @(negedge clk);
        check_eq("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
        check_eq("pre_rst_z", bus.out_z, 32'd7);
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("arst_z", bus.out_z, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check_eq("post_rst_stale", 32'(seen), 32'd0);
        run_vec("p10", 32'h4120_0000, 32'h0000_000A, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
